// File: rtl/types.sv
// types: encodings shared between the fetch stage and the decode controller.
package types;
   typedef enum logic [1:0] {pcPP4 = 2'b00, pcOFS = 2'b01, pcIND = 2'b10} PcSel;
   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} FetchState;
endpackage

// File: rtl/pc_next_logic.sv
// pc_next_logic: next-PC target for an accepted instruction and its fault classification.
module pc_next_logic
   import types::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  pc_sel,
   input  logic [31:0] offset,
   input  logic [31:0] rs1,
   output logic [31:0] target,
   output logic        misaligned,
   output logic        reserved
);
   assign target = (pc_sel == pcOFS) ? pc + offset :
                   (pc_sel == pcIND) ? (rs1 + offset) & ~32'd1 : pc + 32'd4;
   // bit0 is either cleared (indirect) or ignored; only bit1 breaks word alignment
   assign misaligned = target[1];
   assign reserved   = (pc_sel == 2'b11);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage; owns the PC, fetches one word at a time and hands it
// to decode over valid/ready, redirecting on the next-PC select sampled at accept.
module fetch_unit
   import types::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   output logic [31:0] o_MemAddr,
   output logic        o_MemReq,
   input  logic        i_MemAck,
   input  logic [31:0] i_MemData,
   output logic [31:0] o_Inst,
   output logic [31:0] o_PC,
   output logic        o_InstValid,
   input  logic        i_InstReady,
   input  logic [1:0]  i_PCNextSel,
   input  logic [31:0] i_Offset,
   input  logic [31:0] i_RegData,
   output logic [31:0] o_InstCount,
   output logic        o_Fault,
   output logic [31:0] o_FaultAddr
);
   FetchState   state;
   logic [31:0] pc;
   logic [31:0] target;
   logic        misaligned;
   logic        reserved;

   pc_next_logic u_next (
      .pc         (pc),
      .pc_sel     (i_PCNextSel),
      .offset     (i_Offset),
      .rs1        (i_RegData),
      .target     (target),
      .misaligned (misaligned),
      .reserved   (reserved)
   );

   assign o_MemAddr = pc;

   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         state       <= IDLE;
         pc          <= RESET_ADDR;
         o_MemReq    <= 1'b0;
         o_InstValid <= 1'b0;
         o_Inst      <= 32'd0;
         o_PC        <= RESET_ADDR;
         o_InstCount <= 32'd0;
         o_Fault     <= 1'b0;
         o_FaultAddr <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               state    <= FETCH;
               o_MemReq <= 1'b1;
            end
            FETCH: if (i_MemAck) begin
               o_Inst      <= i_MemData;
               o_PC        <= pc;
               o_MemReq    <= 1'b0;
               o_InstValid <= 1'b1;
               state       <= ISSUE;
            end
            ISSUE: if (i_InstReady) begin
               o_InstValid <= 1'b0;
               o_InstCount <= o_InstCount + 32'd1;
               // a faulting redirect leaves the PC at the instruction that raised it
               if (reserved || misaligned) begin
                  o_Fault     <= 1'b1;
                  o_FaultAddr <= reserved ? pc : target;
                  state       <= HALT;
               end else begin
                  pc       <= target;
                  o_MemReq <= 1'b1;
                  state    <= FETCH;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized fetch/decode traffic checked against a
// transaction-level model of the fetch protocol.
module tb_fetch_unit;
   localparam logic [31:0] RA = 32'h0000_0000;
   localparam int P_START = 0, P_REQ = 1, P_VALID = 2, P_HALT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] mem_addr, mem_data = 32'd0, inst, pc_out, inst_count, offset = 32'd0, reg_data = 32'd0, fault_addr;
   logic        mem_req, mem_ack = 1'b0, inst_valid, inst_ready = 1'b0, fault;
   logic [1:0]  next_sel = 2'd0;

   int vectors = 0, miscompares = 0;

   logic [31:0] m_pc, m_inst, m_ipc, m_count, m_faddr;
   logic        m_fault;
   int          m_ph;

   fetch_unit #(.RESET_ADDR(RA)) dut (
      .i_Clock     (clk),
      .i_Reset     (rst_n),
      .o_MemAddr   (mem_addr),
      .o_MemReq    (mem_req),
      .i_MemAck    (mem_ack),
      .i_MemData   (mem_data),
      .o_Inst      (inst),
      .o_PC        (pc_out),
      .o_InstValid (inst_valid),
      .i_InstReady (inst_ready),
      .i_PCNextSel (next_sel),
      .i_Offset    (offset),
      .i_RegData   (reg_data),
      .o_InstCount (inst_count),
      .o_Fault     (fault),
      .o_FaultAddr (fault_addr)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mreset();
      m_pc = RA; m_inst = 32'd0; m_ipc = RA; m_count = 32'd0;
      m_fault = 1'b0; m_faddr = 32'd0; m_ph = P_START;
   endtask

   always @(posedge clk) begin
      #2;
      chk("req", 32'(mem_req), 32'(m_ph == P_REQ));
      chk("valid", 32'(inst_valid), 32'(m_ph == P_VALID));
      if (m_ph == P_REQ) chk("addr", mem_addr, m_pc);
      chk("inst", inst, m_inst);
      chk("pc", pc_out, m_ipc);
      chk("count", inst_count, m_count);
      chk("fault", 32'(fault), 32'(m_fault));
      chk("fault_addr", fault_addr, m_faddr);
   end

   // drives one cycle of memory/decode inputs and advances the model past the coming edge
   task automatic step(input bit ack, input bit rdy, input logic [1:0] sel, input logic [31:0] off, input logic [31:0] rd);
      logic [31:0] t;
      mem_ack = ack;
      mem_data = (ack && mem_req) ? mem(mem_addr) : $urandom;
      inst_ready = rdy; next_sel = sel; offset = off; reg_data = rd;
      case (m_ph)
         P_START: m_ph = P_REQ;
         P_REQ: if (ack) begin
            m_inst = mem(m_pc); m_ipc = m_pc; m_ph = P_VALID;
         end
         P_VALID: if (rdy) begin
            m_count = m_count + 32'd1;
            t = sel == 2'd1 ? m_pc + off : sel == 2'd2 ? (rd + off) & ~32'h1 : m_pc + 32'd4;
            if (sel == 2'd3) begin
               m_fault = 1'b1; m_faddr = m_pc; m_ph = P_HALT;
            end else if (t[1]) begin
               m_fault = 1'b1; m_faddr = t; m_ph = P_HALT;
            end else begin
               m_pc = t; m_ph = P_REQ;
            end
         end
         default: ;
      endcase
      @(negedge clk);
   endtask

   task automatic fetch(input int dly);
      int n = 0;
      bit in_req;
      while (m_ph != P_VALID && m_ph != P_HALT) begin
         in_req = (m_ph == P_REQ);
         step(in_req && n >= dly, 1'b0, 2'd0, 32'd0, 32'd0);
         if (in_req) n++;
      end
   endtask

   task automatic accept(input logic [1:0] sel, input logic [31:0] off, input logic [31:0] rd);
      fetch(0);
      step(1'b0, 1'b1, sel, off, rd);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mreset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_step();
      int r;
      logic [1:0] sel;
      logic [31:0] off, rd;
      r = $urandom_range(0, 99);
      sel = r < 60 ? 2'd0 : r < 80 ? 2'd1 : r < 97 ? 2'd2 : 2'd3;
      off = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom_range(0, 255) - 128) * 4;
      rd = ($urandom_range(0, 3) == 0) ? $urandom : $urandom & ~32'h3;
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, sel, off, rd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      mreset();
      @(negedge clk);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_pc", pc_out, RA);
      chk("rst_count", inst_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // zero-wait, sequential: 1 instruction every 2 cycles
      repeat (3) accept(2'd0, 32'd0, 32'd0);
      chk("seq_count", inst_count, 32'd3);
      chk("seq_addr", mem_addr, 32'hC);

      // delayed ack, decode stall, spurious ack while issuing
      do_reset();
      accept(2'd0, 32'd0, 32'd0);
      fetch(3);
      chk("dly_pc", pc_out, 32'h4);
      repeat (2) step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
      chk("hold_inst", inst, mem(32'h4));
      step(1'b0, 1'b1, 2'd1, 32'hFC, 32'd0);
      chk("jmp_100", mem_addr, 32'h100);
      accept(2'd1, 32'hFFFF_FFF0, 32'd0);
      chk("jmp_back", mem_addr, 32'hF0);
      accept(2'd1, 32'hFFFF_FF0C, 32'd0);
      chk("jmp_top", mem_addr, 32'hFFFF_FFFC);
      accept(2'd0, 32'd0, 32'd0);
      chk("wrap", mem_addr, 32'h0);
      accept(2'd2, 32'h4, 32'h2001);
      chk("ind", mem_addr, 32'h2004);
      accept(2'd2, 32'h0, 32'h2002);
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_addr", fault_addr, 32'h2002);
      repeat (3) step(1'b1, 1'b1, 2'd0, 32'd0, 32'd0);
      chk("halt_req", 32'(mem_req), 32'd0);
      chk("halt_inst", inst, mem(32'h2004));

      // reserved select faults at the current PC
      do_reset();
      accept(2'd1, 32'h40, 32'd0);
      accept(2'd3, 32'd0, 32'd0);
      chk("rsv_addr", fault_addr, 32'h40);
      chk("rsv_count", inst_count, 32'd2);

      // reset mid-fetch with an ack in the same cycle
      do_reset();
      repeat (2) accept(2'd0, 32'd0, 32'd0);
      chk("mid_addr", mem_addr, 32'h8);
      mem_ack = 1'b1; mem_data = mem(32'h8);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_req", 32'(mem_req), 32'd0);
      chk("mid_inst", inst, 32'd0);
      mreset();
      @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      chk("restart_addr", mem_addr, RA);
      chk("restart_count", inst_count, 32'd0);

      for (int s = 0; s < 25; s++) begin
         do_reset();
         for (int c = 0; c < 200 && m_ph != P_HALT; c++) rand_step();
         repeat (4) rand_step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
